// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants and requester IDs for the writeback arbiter
//
// Contents:
//   NUM_REGS  number of architectural registers tracked by the busy scoreboard
//   IDX_W     width of a register index
//   req_id_e  requester identifiers used by the round-robin pointer
package rf_wb_arbiter_pkg;

   localparam int NUM_REGS = 32;
   localparam int IDX_W    = 5;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_id_e;

endpackage : rf_wb_arbiter_pkg

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rtl/rf_wb_arbiter_rr_arb2.sv - two-way round-robin grant between ALU and LSU writeback
//
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous active-high reset; forces both grants low
//   req_alu   ALU request (valid)
//   req_lsu   LSU request (valid)
//   gnt_alu   ALU granted this cycle (combinational)
//   gnt_lsu   LSU granted this cycle (combinational)
module rr_arb2
   import rf_wb_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_alu,
   input  logic req_lsu,
   output logic gnt_alu,
   output logic gnt_lsu
);

   req_id_e prio_q;

   // The pointer only moves on contention, so a lone requester never
   // steals the next turn from the other side.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= REQ_ALU;
      end else if (req_alu && req_lsu) begin
         prio_q <= (prio_q == REQ_ALU) ? REQ_LSU : REQ_ALU;
      end
   end

   always_comb begin
      gnt_alu = 1'b0;
      gnt_lsu = 1'b0;
      if (!reset) begin
         if (req_alu && req_lsu) begin
            gnt_alu = (prio_q == REQ_ALU);
            gnt_lsu = (prio_q == REQ_LSU);
         end else begin
            gnt_alu = req_alu;
            gnt_lsu = req_lsu;
         end
      end
   end

endmodule : rr_arb2

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - ALU/LSU writeback arbiter with register busy scoreboard
//
// Ports:
//   clk, reset                      single clock; synchronous active-high reset
//   alu_valid/alu_rd_idx/alu_data   ALU writeback request
//   alu_ready                       ALU granted this cycle
//   lsu_valid/lsu_rd_idx/lsu_data   LSU writeback request
//   lsu_ready                       LSU granted this cycle
//   issue_en/issue_rd_idx           issued instruction marks its destination busy
//   rs1_idx/rs2_idx                 source indices to look up
//   rs1_busy/rs2_busy               source has a pending write (registered view)
//   rf_wr_en/rf_rd_idx/rf_wr_data   registered register-file write port, one cycle after grant
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DWIDTH = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [IDX_W-1:0]  alu_rd_idx,
   input  logic [DWIDTH-1:0] alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [IDX_W-1:0]  lsu_rd_idx,
   input  logic [DWIDTH-1:0] lsu_data,
   output logic              lsu_ready,
   input  logic              issue_en,
   input  logic [IDX_W-1:0]  issue_rd_idx,
   input  logic [IDX_W-1:0]  rs1_idx,
   input  logic [IDX_W-1:0]  rs2_idx,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              rf_wr_en,
   output logic [IDX_W-1:0]  rf_rd_idx,
   output logic [DWIDTH-1:0] rf_wr_data
);

   logic                grant;
   logic [IDX_W-1:0]    grant_idx;
   logic [DWIDTH-1:0]   grant_data;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_alu (alu_valid),
      .req_lsu (lsu_valid),
      .gnt_alu (alu_ready),
      .gnt_lsu (lsu_ready)
   );

   always_comb begin
      grant      = alu_ready | lsu_ready;
      grant_idx  = alu_ready ? alu_rd_idx : lsu_rd_idx;
      grant_data = alu_ready ? alu_data   : lsu_data;
   end

   // Set is applied after clear so an issue and a writeback to the same
   // register in one cycle leaves it busy for the newer instruction.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (issue_en && (issue_rd_idx == i[IDX_W-1:0])) begin
            set_mask[i] = 1'b1;
         end
         if (grant && (grant_idx == i[IDX_W-1:0])) begin
            clr_mask[i] = 1'b1;
         end
      end
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Lookups see only the registered scoreboard; same-cycle updates are
   // deliberately not forwarded.
   always_comb begin
      rs1_busy = busy_q[rs1_idx];
      rs2_busy = busy_q[rs2_idx];
   end

   // Writes to x0 still consume the grant but never pulse the write enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_wr_en   <= 1'b0;
         rf_rd_idx  <= '0;
         rf_wr_data <= '0;
      end else begin
         rf_wr_en <= grant && (grant_idx != '0);
         if (grant) begin
            rf_rd_idx  <= grant_idx;
            rf_wr_data <= grant_data;
         end
      end
   end

endmodule : rf_wb_arbiter

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd_idx;
   logic [63:0] alu_data;
   logic        alu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd_idx;
   logic [63:0] lsu_data;
   logic        lsu_ready;
   logic        issue_en;
   logic [4:0]  issue_rd_idx;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rf_wr_en;
   logic [4:0]  rf_rd_idx;
   logic [63:0] rf_wr_data;

   rf_wb_arbiter #(.DWIDTH(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_rd_idx   (alu_rd_idx),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .lsu_valid    (lsu_valid),
      .lsu_rd_idx   (lsu_rd_idx),
      .lsu_data     (lsu_data),
      .lsu_ready    (lsu_ready),
      .issue_en     (issue_en),
      .issue_rd_idx (issue_rd_idx),
      .rs1_idx      (rs1_idx),
      .rs2_idx      (rs2_idx),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .rf_wr_en     (rf_wr_en),
      .rf_rd_idx    (rf_rd_idx),
      .rf_wr_data   (rf_wr_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model state
   bit          m_busy [32];
   bit          alu_turn;
   bit          m_we;
   bit [4:0]    m_idx;
   bit [63:0]   m_data;
   bit          g_alu;
   bit          g_lsu;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_rd_idx = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd_idx = 0; lsu_data = 0;
      issue_en = 0; issue_rd_idx = 0;
   endtask

   // Called at a falling edge with inputs already applied: checks the
   // combinational outputs, advances one clock, updates the model and
   // checks the registered outputs at the next falling edge.
   task automatic step();
      bit       e_alu, e_lsu;
      bit [4:0] gidx;
      #1;
      e_alu = 0; e_lsu = 0;
      if (!reset) begin
         if (alu_valid && lsu_valid) begin
            e_alu = alu_turn;
            e_lsu = !alu_turn;
         end else begin
            e_alu = alu_valid;
            e_lsu = lsu_valid;
         end
      end
      check("alu_ready", alu_ready, e_alu);
      check("lsu_ready", lsu_ready, e_lsu);
      check("rs1_busy", rs1_busy, m_busy[rs1_idx]);
      check("rs2_busy", rs2_busy, m_busy[rs2_idx]);
      @(posedge clk);
      if (reset) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         alu_turn = 1; m_we = 0; m_idx = 0; m_data = 0;
      end else begin
         if (alu_valid && lsu_valid) alu_turn = !alu_turn;
         m_we = 0;
         if (e_alu || e_lsu) begin
            gidx   = e_alu ? alu_rd_idx : lsu_rd_idx;
            m_data = e_alu ? alu_data : lsu_data;
            m_idx  = gidx;
            m_we   = (gidx != 0);
            m_busy[gidx] = 0;
         end
         if (issue_en && issue_rd_idx != 0) m_busy[issue_rd_idx] = 1;
      end
      g_alu = e_alu;
      g_lsu = e_lsu;
      @(negedge clk);
      check("rf_wr_en", rf_wr_en, m_we);
      check("rf_rd_idx", rf_rd_idx, m_idx);
      check("rf_wr_data", rf_wr_data, m_data);
   endtask

   initial begin
      foreach (m_busy[i]) m_busy[i] = 0;
      alu_turn = 1; m_we = 0; m_idx = 0; m_data = 0;
      reset = 1; rs1_idx = 0; rs2_idx = 0;
      idle_inputs();
      @(negedge clk);
      step();
      step();
      reset = 0;

      // Issue r5, then ALU writes it back
      issue_en = 1; issue_rd_idx = 5; rs1_idx = 5;
      step();
      issue_en = 0;
      check("r5_busy_before_wb", rs1_busy, 1);
      alu_valid = 1; alu_rd_idx = 5; alu_data = 64'hA5;
      step();
      alu_valid = 0;
      check("r5_write_en", rf_wr_en, 1);
      check("r5_write_data", rf_wr_data, 64'hA5);
      check("r5_busy_after_wb", rs1_busy, 0);

      // Contention for four cycles: ALU, LSU, ALU, LSU
      for (int k = 0; k < 4; k++) begin
         alu_valid = 1; lsu_valid = 1;
         alu_rd_idx = 5'(10 + k); alu_data = 64'(100 + k);
         lsu_rd_idx = 5'(20 + k); lsu_data = 64'(200 + k);
         step();
         check("alternate_alu", g_alu, (k % 2) == 0);
         check("alternate_wr_idx", rf_rd_idx, (k % 2) == 0 ? 10 + k : 20 + k);
      end
      idle_inputs();

      // LSU write to x0
      lsu_valid = 1; lsu_rd_idx = 0; lsu_data = 64'hFF;
      step();
      lsu_valid = 0;
      check("x0_no_write", rf_wr_en, 0);

      // Same-cycle issue and writeback to r7: set wins
      issue_en = 1; issue_rd_idx = 7; rs1_idx = 7;
      step();
      alu_valid = 1; alu_rd_idx = 7; alu_data = 64'h77;
      step();
      idle_inputs();
      check("r7_stays_busy", rs1_busy, 1);

      // Grant then reset drops the staged write
      alu_valid = 1; alu_rd_idx = 3; alu_data = 64'h33;
      step();
      alu_valid = 0; reset = 1;
      step();
      check("reset_drops_write", rf_wr_en, 0);
      check("reset_clears_busy", rs1_busy, 0);
      reset = 0;
      alu_valid = 1; lsu_valid = 1; alu_rd_idx = 1; lsu_rd_idx = 2;
      step();
      check("alu_first_after_reset", g_alu, 1);
      idle_inputs();

      // Randomized traffic with requesters holding until granted
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 49) == 0);
         if (!(alu_valid && !g_alu) || reset) begin
            alu_valid  = $urandom_range(0, 1);
            alu_rd_idx = 5'($urandom_range(0, 31));
            alu_data   = {$urandom, $urandom};
         end
         if (!(lsu_valid && !g_lsu) || reset) begin
            lsu_valid  = $urandom_range(0, 1);
            lsu_rd_idx = 5'($urandom_range(0, 31));
            lsu_data   = {$urandom, $urandom};
         end
         issue_en     = $urandom_range(0, 1);
         issue_rd_idx = 5'($urandom_range(0, 31));
         rs1_idx      = 5'($urandom_range(0, 31));
         rs2_idx      = 5'($urandom_range(0, 31));
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_rf_wb_arbiter
